accumulator_frame_nbit: RTL and testbench

Parametrised framed accumulator: sums NUM_SAMPLES operands (add or subtract per sample) into a WIDTH-bit register, then presents the frame result with sticky carry/overflow flags over a valid/ready handshake. Input and output sides both use valid/ready. Sits between sample producers and downstream arithmetic/reporting blocks. Generalises the fixed 8-bit free-running accumulator: adds width, frame length, signedness, per-sample subtract, synchronous clear and back-pressure.

---
 rtl/accumulator_frame_nbit_pkg.sv | 20 ++
 rtl/accumulator_frame_nbit_if.sv | 30 +++
 rtl/accumulator_frame_nbit_addsub.sv | 23 ++
 rtl/accumulator_frame_nbit.sv | 147 ++++++++++++++
 tb/tb_accumulator_frame_nbit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/accumulator_frame_nbit_pkg.sv
// Shared types and helpers for the framed accumulator.
package accumulator_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RUN  = 2'd1,
    ACC_DONE = 2'd2
  } acc_state_e;

  // Largest two's-complement value representable in w bits (low w bits used).
  function automatic logic [63:0] acc_smax(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value in w bits (low w bits used).
  function automatic logic [63:0] acc_smin(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/accumulator_frame_nbit_if.sv
// Sample-in / result-out valid-ready bus of the framed accumulator.
interface accumulator_frame_nbit_if #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_SAMPLES = 4
);
  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_carry;
  logic             o_ovf;
  logic [CNT_W-1:0] o_cnt;

  // Accumulator side.
  modport slave (
    input  i_valid, i_a, i_sub, i_ready,
    output o_ready, o_valid, o_s, o_carry, o_ovf, o_cnt
  );

  // Producer / consumer side.
  modport master (
    output i_valid, i_a, i_sub, i_ready,
    input  o_ready, o_valid, o_s, o_carry, o_ovf, o_cnt
  );
endinterface

// File: rtl/accumulator_frame_nbit_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry/borrow and signed overflow.
module acc_addsub_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);
  logic [WIDTH:0] ext;

  // One extra bit captures carry-out on add and borrow (a < b) on subtract.
  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b};
    else     ext = {1'b0, a} + {1'b0, b};
    sum   = ext[WIDTH-1:0];
    carry = ext[WIDTH];
    if (sub) ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else     ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/accumulator_frame_nbit.sv
// Framed accumulator: sums NUM_SAMPLES add/sub operands, then offers the result
// with sticky carry/overflow over valid/ready.
// Optional macro ACC_SAT_EN: saturate on overflow/carry instead of wrapping.
module accumulator_frame_nbit
  import accumulator_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_SAMPLES = 4,
  parameter bit          SIGNED      = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     ni_rst,
  input  logic                     i_clr,
  accumulator_frame_nbit_if.slave  bus
);
  localparam int unsigned      CNT_W    = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] acc_res;
  logic             raw_carry;
  logic             raw_ovf;
  logic             accept;

  acc_addsub_nbit #(.WIDTH(WIDTH)) u_addsub (
    .a     (s_q),
    .b     (bus.i_a),
    .sub   (bus.i_sub),
    .sum   (raw_sum),
    .carry (raw_carry),
    .ovf   (raw_ovf)
  );

`ifdef ACC_SAT_EN
  // Clamp the raw result to the representable range on overflow/carry.
  always_comb begin
    acc_res = raw_sum;
    if (SIGNED) begin
      if (raw_ovf) acc_res = s_q[WIDTH-1] ? WIDTH'(acc_smin(WIDTH)) : WIDTH'(acc_smax(WIDTH));
    end else if (raw_carry) begin
      acc_res = bus.i_sub ? '0 : '1;
    end
  end
`else
  // Pure modulo arithmetic; signedness only matters for saturation.
  logic unused_signed;
  assign unused_signed = SIGNED;
  assign acc_res       = raw_sum;
`endif

  // ready_q mirrors "not in ACC_DONE", so accept has no path from i_ready.
  assign accept = bus.i_valid && ready_q;

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    ready_d = ready_q;
    if (i_clr) begin
      state_d = ACC_IDLE;
      s_d     = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        ACC_IDLE, ACC_RUN: begin
          if (accept) begin
            s_d     = acc_res;
            cnt_d   = cnt_q + CNT_W'(1);
            carry_d = carry_q | raw_carry;
            ovf_d   = ovf_q | raw_ovf;
            if (cnt_q == LAST_CNT) begin
              state_d = ACC_DONE;
              valid_d = 1'b1;
              ready_d = 1'b0;
            end else begin
              state_d = ACC_RUN;
            end
          end
        end
        ACC_DONE: begin
          if (bus.i_ready) begin
            state_d = ACC_IDLE;
            s_d     = '0;
            cnt_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = ACC_IDLE;
          s_d     = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q <= ACC_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_s     = s_q;
  assign bus.o_cnt   = cnt_q;
  assign bus.o_carry = carry_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ready = ready_q;
endmodule

// File: tb/tb_accumulator_frame_nbit.sv
// Self-checking bench for accumulator_frame_nbit (WIDTH=8, NUM_SAMPLES=4, SIGNED=1).
module tb_accumulator_frame_nbit;
  localparam int unsigned W     = 8;
  localparam int unsigned N     = 4;
  localparam bit          SGN   = 1'b1;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int          FULL  = 256;
  localparam int          HALF  = 128;

  logic i_clk = 1'b0;
  logic ni_rst = 1'b0;
  logic i_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state: unsigned accumulator value, sticky flags, sample count.
  int m_s, m_cnt;
  bit m_c, m_o;

  accumulator_frame_nbit_if #(.WIDTH(W), .NUM_SAMPLES(N)) bus ();

  accumulator_frame_nbit #(.WIDTH(W), .NUM_SAMPLES(N), .SIGNED(SGN)) dut (
    .i_clk  (i_clk),
    .ni_rst (ni_rst),
    .i_clr  (i_clr),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void model_clear();
    m_s = 0; m_cnt = 0; m_c = 1'b0; m_o = 1'b0;
  endfunction

  // Apply one sample using integer arithmetic on unsigned and signed views.
  function automatic void model_apply(input int a, input bit sub);
    int pu, ps, as_v, fu, fs, res;
    bit c, o;
    pu   = m_s;
    ps   = (pu >= HALF) ? pu - FULL : pu;
    as_v = (a >= HALF) ? a - FULL : a;
    fu   = sub ? pu - a : pu + a;
    fs   = sub ? ps - as_v : ps + as_v;
    c    = sub ? (pu < a) : (fu >= FULL);
    o    = (fs >= HALF) || (fs < -HALF);
    res  = fu & (FULL - 1);
`ifdef ACC_SAT_EN
    if (SGN) begin
      if (o) res = (ps >= 0) ? HALF - 1 : HALF;
    end else if (c) begin
      res = sub ? 0 : FULL - 1;
    end
`endif
    m_s   = res;
    m_c   = m_c | c;
    m_o   = m_o | o;
    m_cnt = m_cnt + 1;
  endfunction

  task automatic drive(input int a, input bit sub);
    bus.i_valid = 1'b1;
    bus.i_a     = W'(a);
    bus.i_sub   = sub;
    step();
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_sub = 1'b0; bus.i_ready = 1'b0;
    step(); step();
    ni_rst = 1'b1;
    step();
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", bus.o_ready); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.o_valid); end
    drive(7, 1'b0);
    drive(9, 1'b0);
    bus.i_valid = 1'b0;
    total++; if (bus.o_s !== 8'd16) begin bad++; $display("FAIL pre_rst_s got=%0h want=10", bus.o_s); end
    #3 ni_rst = 1'b0;
    #1;
    total++; if (bus.o_s !== 8'd0) begin bad++; $display("FAIL async_rst_s got=%0h want=0", bus.o_s); end
    total++; if (bus.o_cnt !== CNT_W'(0)) begin bad++; $display("FAIL async_rst_cnt got=%0d want=0", bus.o_cnt); end
    total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL async_rst_hs got=%0b%0b want=10", bus.o_ready, bus.o_valid); end
    total++; if (bus.o_carry !== 1'b0 || bus.o_ovf !== 1'b0) begin
      bad++; $display("FAIL async_rst_flags got=%0b%0b want=00", bus.o_carry, bus.o_ovf); end
    step();
    ni_rst = 1'b1;
    step();
  endtask

  task automatic test_add_frame();
    int vals[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid idx=%0d got=%0b want=0", i, bus.o_valid); end
      drive(vals[i], 1'b0);
      total++; if (bus.o_cnt !== CNT_W'(i + 1)) begin bad++; $display("FAIL add_cnt got=%0d want=%0d", bus.o_cnt, i + 1); end
    end
    bus.i_valid = 1'b0;
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%0b want=1", bus.o_valid); end
    total++; if (bus.o_s !== 8'd100) begin bad++; $display("FAIL add_sum got=%0d want=100", bus.o_s); end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL add_ready got=%0b want=0", bus.o_ready); end
    total++; if (bus.o_carry !== 1'b0 || bus.o_ovf !== 1'b0) begin
      bad++; $display("FAIL add_flags got=%0b%0b want=00", bus.o_carry, bus.o_ovf); end
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_valid = 1'b1; bus.i_a = 8'd55;
      step();
      total++; if (bus.o_valid !== 1'b1 || bus.o_s !== 8'd100 || bus.o_cnt !== CNT_W'(N)) begin
        bad++; $display("FAIL add_hold got=%0b/%0d/%0d want=1/100/4", bus.o_valid, bus.o_s, bus.o_cnt); end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    total++; if (bus.o_valid !== 1'b0 || bus.o_s !== 8'd0 || bus.o_cnt !== CNT_W'(0) || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL add_drain got=%0b/%0d/%0d/%0b want=0/0/0/1", bus.o_valid, bus.o_s, bus.o_cnt, bus.o_ready); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_s;
`ifdef ACC_SAT_EN
    exp_s = 8'h7F;
`else
    exp_s = 8'hC8;
`endif
    drive(100, 1'b0);
    drive(100, 1'b0);
    total++; if (bus.o_s !== exp_s || bus.o_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_mid got=%0h/%0b want=%0h/1", bus.o_s, bus.o_ovf, exp_s); end
    drive(0, 1'b0);
    drive(0, 1'b0);
    bus.i_valid = 1'b0;
    total++; if (bus.o_s !== exp_s) begin bad++; $display("FAIL ovf_sum got=%0h want=%0h", bus.o_s, exp_s); end
    total++; if (bus.o_ovf !== 1'b1 || bus.o_carry !== 1'b0) begin
      bad++; $display("FAIL ovf_flags got=%0b%0b want=01", bus.o_carry, bus.o_ovf); end
    bus.i_ready = 1'b1; step(); bus.i_ready = 1'b0;
  endtask

  task automatic test_subtract();
    drive(5, 1'b0);
    drive(3, 1'b1);
    total++; if (bus.o_carry !== 1'b0) begin bad++; $display("FAIL sub_early_carry got=%0b want=0", bus.o_carry); end
    drive(10, 1'b1);
    drive(1, 1'b0);
    bus.i_valid = 1'b0;
    total++; if (bus.o_s !== 8'hF9) begin bad++; $display("FAIL sub_sum got=%0h want=f9", bus.o_s); end
    total++; if (bus.o_carry !== 1'b1 || bus.o_ovf !== 1'b0) begin
      bad++; $display("FAIL sub_flags got=%0b%0b want=10", bus.o_carry, bus.o_ovf); end
    bus.i_ready = 1'b1; step(); bus.i_ready = 1'b0;
  endtask

  task automatic test_clear();
    drive(11, 1'b0);
    drive(22, 1'b0);
    i_clr = 1'b1;
    drive(33, 1'b0);
    i_clr = 1'b0;
    total++; if (bus.o_s !== 8'd0 || bus.o_cnt !== CNT_W'(0) || bus.o_ready !== 1'b1) begin
      bad++; $display("FAIL clr_state got=%0d/%0d/%0b want=0/0/1", bus.o_s, bus.o_cnt, bus.o_ready); end
    drive(1, 1'b0); drive(2, 1'b0); drive(3, 1'b0);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL clr_early_valid got=%0b want=0", bus.o_valid); end
    drive(4, 1'b0);
    bus.i_valid = 1'b0;
    total++; if (bus.o_valid !== 1'b1 || bus.o_s !== 8'd10) begin
      bad++; $display("FAIL clr_frame got=%0b/%0d want=1/10", bus.o_valid, bus.o_s); end
    bus.i_ready = 1'b1; step(); bus.i_ready = 1'b0;
  endtask

  // Random traffic against the model; hold_valid keeps the producer always offering.
  task automatic test_random(input int cycles, input bit hold_valid, input bit use_clr);
    int a;
    bit v, s, r, c;
    model_clear();
    for (int i = 0; i < cycles; i++) begin
      total++; if (bus.o_ready !== (m_cnt != N) || bus.o_valid !== (m_cnt == N)) begin
        bad++; $display("FAIL rnd_hs cyc=%0d got=%0b%0b want=%0b%0b", i, bus.o_ready, bus.o_valid, m_cnt != N, m_cnt == N); end
      total++; if (bus.o_s !== W'(m_s) || bus.o_cnt !== CNT_W'(m_cnt)) begin
        bad++; $display("FAIL rnd_data cyc=%0d got=%0h/%0d want=%0h/%0d", i, bus.o_s, bus.o_cnt, m_s, m_cnt); end
      total++; if (bus.o_carry !== m_c || bus.o_ovf !== m_o) begin
        bad++; $display("FAIL rnd_flags cyc=%0d got=%0b%0b want=%0b%0b", i, bus.o_carry, bus.o_ovf, m_c, m_o); end
      a = int'($urandom_range(0, FULL - 1));
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      v = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
      c = use_clr && ($urandom_range(0, 15) == 0);
      bus.i_valid = v; bus.i_a = W'(a); bus.i_sub = s; bus.i_ready = r; i_clr = c;
      if (c) model_clear();
      else if (m_cnt == N) begin
        if (r) model_clear();
      end else if (v) model_apply(a, s);
      step();
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; i_clr = 1'b0;
    i_clr = 1'b1; step(); i_clr = 1'b0;
  endtask

  initial begin
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_sub = 1'b0; bus.i_ready = 1'b0;
    test_reset();
    test_add_frame();
    test_overflow();
    test_subtract();
    test_clear();
    test_random(40, 1'b1, 1'b0);
    test_random(300, 1'b0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
